// File: rtl/matmul_pkg.sv
// Shared constants, FSM encoding and operand tag layout for the
// matrix-multiply operand fetch stage.
package matmul_pkg;

    localparam int N      = 4;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_e;

    // Tag travelling with each operand pair: destination C index plus
    // dot-product boundary markers.
    typedef struct packed {
        logic [ADDR_W-1:0] c_idx;
        logic              first;
        logic              last;
    } op_tag_t;

    localparam int TAG_W = $bits(op_tag_t);

endpackage

// File: rtl/operand_skid_fifo.sv
// Two-entry synchronous FIFO holding returned operand pairs and their tags.
// The head entry is presented combinationally from storage registers.
module operand_skid_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_q;
    logic             rd_q;
    logic [1:0]       cnt_q;
    logic [1:0]       cnt_d;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign pop_ok_s  = pop_i && (cnt_q != 2'd0);
    assign push_ok_s = push_i && ((cnt_q != 2'd2) || pop_ok_s);
    assign data_o    = mem_q[rd_q];
    assign count_o   = cnt_q;

    // Occupancy update: simultaneous push and pop leaves it unchanged.
    always_comb begin
        cnt_d = cnt_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage, pointers and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= {WIDTH{1'b0}};
            mem_q[1] <= {WIDTH{1'b0}};
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= ~wr_q;
            end
            if (pop_ok_s) begin
                rd_q <= ~rd_q;
            end
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/matrix_operand_fetch.sv
// Operand sequencer for C = A x B: walks i/j/k (k innermost), reads A and B
// BRAMs and streams tagged operand pairs to the multiplier stage.
module matrix_operand_fetch #(
    parameter int N      = matmul_pkg::N,
    parameter int DATA_W = matmul_pkg::DATA_W,
    parameter int ADDR_W = matmul_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              en_a,
    output logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] dout_a,
    output logic              en_b,
    output logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] dout_b,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [ADDR_W-1:0] op_c_idx,
    output logic              op_first,
    output logic              op_last,
    output logic              op_valid,
    input  logic              op_ready
);

    import matmul_pkg::*;

    localparam int                FIFO_W   = 2 * DATA_W + ADDR_W + 2;
    localparam logic [ADDR_W-1:0] ZERO     = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] STEP_N   = ADDR_W'(N);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);

    fetch_state_e      state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] i_q, i_d;
    logic [ADDR_W-1:0] j_q, j_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [ADDR_W-1:0] a_row_q, a_row_d;    // running i*N
    logic [ADDR_W-1:0] a_ptr_q, a_ptr_d;    // running i*N+k
    logic [ADDR_W-1:0] b_ptr_q, b_ptr_d;    // running k*N+j
    logic [ADDR_W-1:0] c_q, c_d;            // running i*N+j
    logic [ADDR_W-1:0] tag_c_q;
    logic              tag_first_q;
    logic              tag_last_q;
    logic              inflight_q;

    logic              issue_s;
    logic              last_issue_s;
    logic              pop_s;
    logic [1:0]        fifo_cnt_s;
    logic [2:0]        outstanding_s;
    logic [FIFO_W-1:0] head_s;
    logic [FIFO_W-1:0] push_data_s;

    // Credit counts the slot freed by a pop in the same cycle so that a
    // continuously ready consumer sees one pair per clock.
    assign pop_s         = op_valid && op_ready;
    assign outstanding_s = {1'b0, fifo_cnt_s} - {2'b00, pop_s} + {2'b00, inflight_q};
    assign issue_s       = (state_q == ST_RUN) && (outstanding_s < 3'd2);
    assign last_issue_s  = issue_s && (i_q == LAST_IDX) && (j_q == LAST_IDX) && (k_q == LAST_IDX);

    assign en_a   = issue_s;
    assign en_b   = issue_s;
    assign addr_a = a_ptr_q;
    assign addr_b = b_ptr_q;
    assign busy   = busy_q;
    assign done   = done_q;

    assign push_data_s = {dout_a, dout_b, tag_c_q, tag_first_q, tag_last_q};

    operand_skid_fifo #(
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (inflight_q),
        .data_i  (push_data_s),
        .pop_i   (pop_s),
        .data_o  (head_s),
        .count_o (fifo_cnt_s)
    );

    assign op_valid = (fifo_cnt_s != 2'd0);
    assign op_a     = head_s[FIFO_W-1 -: DATA_W];
    assign op_b     = head_s[ADDR_W+2 +: DATA_W];
    assign op_c_idx = head_s[2 +: ADDR_W];
    assign op_first = head_s[1];
    assign op_last  = head_s[0];

    // Next-state and status decode for the run sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_issue_s) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if ((fifo_cnt_s == 2'd0) && !inflight_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    // Loop counters and running address sums; k carries into j, j into i.
    always_comb begin
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        a_row_d = a_row_q;
        a_ptr_d = a_ptr_q;
        b_ptr_d = b_ptr_q;
        c_d     = c_q;
        if ((state_q == ST_IDLE) && start) begin
            i_d     = ZERO;
            j_d     = ZERO;
            k_d     = ZERO;
            a_row_d = ZERO;
            a_ptr_d = ZERO;
            b_ptr_d = ZERO;
            c_d     = ZERO;
        end else if (issue_s) begin
            if (k_q == LAST_IDX) begin
                k_d = ZERO;
                c_d = c_q + ONE;
                if (j_q == LAST_IDX) begin
                    j_d     = ZERO;
                    a_row_d = a_row_q + STEP_N;
                    a_ptr_d = a_row_q + STEP_N;
                    b_ptr_d = ZERO;
                    if (i_q == LAST_IDX) begin
                        i_d = ZERO;
                    end else begin
                        i_d = i_q + ONE;
                    end
                end else begin
                    j_d     = j_q + ONE;
                    a_ptr_d = a_row_q;
                    b_ptr_d = j_q + ONE;
                end
            end else begin
                k_d     = k_q + ONE;
                a_ptr_d = a_ptr_q + ONE;
                b_ptr_d = b_ptr_q + STEP_N;
            end
        end else begin
            c_d = c_q;
        end
    end

    // State, counters, and the tag registered alongside each read request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            i_q         <= ZERO;
            j_q         <= ZERO;
            k_q         <= ZERO;
            a_row_q     <= ZERO;
            a_ptr_q     <= ZERO;
            b_ptr_q     <= ZERO;
            c_q         <= ZERO;
            tag_c_q     <= ZERO;
            tag_first_q <= 1'b0;
            tag_last_q  <= 1'b0;
            inflight_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            a_row_q    <= a_row_d;
            a_ptr_q    <= a_ptr_d;
            b_ptr_q    <= b_ptr_d;
            c_q        <= c_d;
            inflight_q <= issue_s;
            if (issue_s) begin
                tag_c_q     <= c_q;
                tag_first_q <= (k_q == ZERO);
                tag_last_q  <= (k_q == LAST_IDX);
            end
        end
    end

endmodule
